// File: rtl/cache_merge_sink_fifo_if.sv
// Handshake bundle between the merge stage, the sink FIFO and the cache controller.
// master: upstream merge plus consumer side; slave: the sink FIFO itself.
interface cache_merge_sink_fifo_if #(
    parameter int unsigned AW = 2
);
    logic          i_drive;
    logic          i_data;
    logic          o_free;
    logic          o_valid;
    logic          o_data;
    logic          i_ready;
    logic [AW:0]   o_count;
    logic          o_full;
    logic          o_err;

    modport master (
        output i_drive, i_data, i_ready,
        input  o_free, o_valid, o_data, o_count, o_full, o_err
    );

    modport slave (
        input  i_drive, i_data, i_ready,
        output o_free, o_valid, o_data, o_count, o_full, o_err
    );
endinterface

// File: rtl/cache_merge_sink_fifo.sv
// Receive stage behind the two-way request merge: buffers single-bit events in a small
// FIFO, acknowledges each accepted event with a one-cycle free pulse, and parks one event
// in a hold slot while the FIFO is full (its free is withheld until it is written).
// Optional macro CACHE_MERGE_SINK_ERR_EN enables the sticky protocol-violation flag o_err;
// without it o_err is tied low.
module cache_merge_sink_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input logic                   clk,
    input logic                   rstn,   // synchronous, active-high
    cache_merge_sink_fifo_if.slave bus
);

    localparam logic [0:0]  StIdle   = 1'b0;
    localparam logic [0:0]  StPend   = 1'b1;
    localparam logic [AW:0] CountMax = (AW + 1)'(DEPTH);

    logic [0:0]    state_q, state_d;
    logic          hold_q, hold_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          free_q;
    logic          mem_q [DEPTH];

    logic valid, full, pop, wr_req, wr_en, wr_bit;

    assign valid = (count_q != '0);
    assign full  = (count_q == CountMax);
    assign pop   = valid & bus.i_ready;

    // Write source selection, hold-slot FSM and occupancy next state
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        count_d = count_q;

        // In PEND the hold slot is the only writer; a fresh drive there is dropped.
        wr_req = (state_q == StIdle) ? bus.i_drive : 1'b1;
        wr_bit = (state_q == StPend) ? hold_q : bus.i_data;
        // A pop frees a slot at the same edge, so full-with-pop still accepts.
        wr_en  = wr_req & (~full | pop);

        if (state_q == StIdle) begin
            if (bus.i_drive && full && !pop) begin
                state_d = StPend;
                hold_d  = bus.i_data;
            end
        end else if (pop) begin
            state_d = StIdle;
        end

        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state, pointers and the registered free pulse
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q  <= StIdle;
            hold_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            free_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            count_q  <= count_d;
            free_q   <= wr_en;
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Storage array; contents need no reset because occupancy gates visibility
    always_ff @(posedge clk) begin
        if (!rstn && wr_en) mem_q[wr_ptr_q] <= wr_bit;
    end

`ifdef CACHE_MERGE_SINK_ERR_EN
    logic err_q;

    // Sticky flag: drive while an event is parked, or drive in the free cycle
    always_ff @(posedge clk) begin
        if (rstn) begin
            err_q <= 1'b0;
        end else if (bus.i_drive && ((state_q == StPend) || free_q)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.o_err = err_q;
`else
    assign bus.o_err = 1'b0;
`endif

    assign bus.o_free  = free_q;
    assign bus.o_valid = valid;
    assign bus.o_data  = valid ? mem_q[rd_ptr_q] : 1'b0;
    assign bus.o_count = count_q;
    assign bus.o_full  = full;

endmodule

// File: tb/tb_cache_merge_sink_fifo.sv
// Scoreboard bench for cache_merge_sink_fifo: accepted events push their bit into an
// expected queue; a negedge monitor pops and compares on every consumer handshake.
module tb_cache_merge_sink_fifo;

    logic clk;
    logic rstn;
    int   errors;
    int   checks;
    bit   exp_q [$];

    cache_merge_sink_fifo_if #(.AW(2)) bus ();

    cache_merge_sink_fifo #(
        .DEPTH (4),
        .AW    (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepted event: expect free in the next cycle only
    task automatic send_acc(input bit d);
        exp_q.push_back(d);
        bus.i_drive = 1'b1;
        bus.i_data  = d;
        tick();
        bus.i_drive = 1'b0;
        bus.i_data  = 1'b0;
        chk("free_ack", int'(bus.o_free), 1);
        tick();
        chk("free_once", int'(bus.o_free), 0);
    endtask

    task automatic drain(input int cycles);
        bus.i_ready = 1'b1;
        repeat (cycles) tick();
        bus.i_ready = 1'b0;
        chk("drain_valid", int'(bus.o_valid), 0);
        chk("drain_count", int'(bus.o_count), 0);
    endtask

    task automatic do_reset();
        rstn = 1'b1;
        tick();
        exp_q.delete();
        rstn = 1'b0;
    endtask

    // Monitor: every handshake must match the head of the expected queue
    always @(negedge clk) begin
        if (!rstn && bus.o_valid && bus.i_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got %0d expected no output at %0t", bus.o_data, $time);
            end else begin
                chk("sb_data", int'(bus.o_data), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        bit [9:0] wrap_pat;
        int       exp_err;
        errors       = 0;
        checks       = 0;
        bus.i_drive  = 1'b0;
        bus.i_data   = 1'b0;
        bus.i_ready  = 1'b0;
        rstn         = 1'b1;
        repeat (3) tick();
        rstn = 1'b0;

        // Reset state
        chk("rst_free",  int'(bus.o_free),  0);
        chk("rst_valid", int'(bus.o_valid), 0);
        chk("rst_data",  int'(bus.o_data),  0);
        chk("rst_count", int'(bus.o_count), 0);
        chk("rst_full",  int'(bus.o_full),  0);
        chk("rst_err",   int'(bus.o_err),   0);

        // Single event: visible with free in the following cycle
        exp_q.push_back(1'b1);
        bus.i_drive = 1'b1;
        bus.i_data  = 1'b1;
        chk("single_nofree_early", int'(bus.o_free), 0);
        tick();
        bus.i_drive = 1'b0;
        bus.i_data  = 1'b0;
        chk("single_free",  int'(bus.o_free),  1);
        chk("single_valid", int'(bus.o_valid), 1);
        chk("single_data",  int'(bus.o_data),  1);
        chk("single_count", int'(bus.o_count), 1);
        tick();
        chk("single_free_once", int'(bus.o_free), 0);
        drain(2);

        // Fill to full, then stream out in order
        send_acc(1'b1);
        send_acc(1'b0);
        send_acc(1'b1);
        send_acc(1'b1);
        chk("fill_full",  int'(bus.o_full),  1);
        chk("fill_count", int'(bus.o_count), 4);
        drain(5);

        // Full with no pop: event parked, free withheld until the first pop
        send_acc(1'b1);
        send_acc(1'b0);
        send_acc(1'b0);
        send_acc(1'b1);
        exp_q.push_back(1'b0);
        bus.i_drive = 1'b1;
        bus.i_data  = 1'b0;
        tick();
        bus.i_drive = 1'b0;
        chk("pend_nofree", int'(bus.o_free), 0);
        tick();
        tick();
        chk("pend_nofree2", int'(bus.o_free), 0);
        chk("pend_count",   int'(bus.o_count), 4);
        bus.i_ready = 1'b1;
        chk("pend_pop_cycle_free", int'(bus.o_free), 0);
        tick();
        bus.i_ready = 1'b0;
        chk("pend_free",  int'(bus.o_free),  1);
        chk("pend_count_kept", int'(bus.o_count), 4);
        tick();
        chk("pend_free_once", int'(bus.o_free), 0);
        drain(6);

        // Full with drive and pop in the same cycle: direct write, no parking
        send_acc(1'b0);
        send_acc(1'b1);
        send_acc(1'b1);
        send_acc(1'b0);
        exp_q.push_back(1'b1);
        bus.i_drive = 1'b1;
        bus.i_data  = 1'b1;
        bus.i_ready = 1'b1;
        tick();
        bus.i_drive = 1'b0;
        bus.i_ready = 1'b0;
        chk("direct_free",  int'(bus.o_free),  1);
        chk("direct_count", int'(bus.o_count), 4);
        tick();
        chk("direct_free_once", int'(bus.o_free), 0);
        drain(6);

        // Pointer wrap with the consumer always ready
        wrap_pat    = 10'b1101001110;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_acc(wrap_pat[i]);
            chk("wrap_count_le1", int'(bus.o_count <= 3'd1), 1);
        end
        drain(2);

        // Mid-operation reset discards contents without free
        send_acc(1'b1);
        send_acc(1'b1);
        do_reset();
        chk("midrst_count", int'(bus.o_count), 0);
        chk("midrst_valid", int'(bus.o_valid), 0);
        chk("midrst_data",  int'(bus.o_data),  0);
        chk("midrst_free",  int'(bus.o_free),  0);

        // Protocol violation: second drive while an event is parked
`ifdef CACHE_MERGE_SINK_ERR_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        send_acc(1'b1);
        send_acc(1'b1);
        send_acc(1'b0);
        send_acc(1'b0);
        exp_q.push_back(1'b1);
        bus.i_drive = 1'b1;
        bus.i_data  = 1'b1;
        tick();
        bus.i_data  = 1'b0;
        chk("viol_pre_err", int'(bus.o_err), 0);
        tick();
        bus.i_drive = 1'b0;
        chk("viol_err", int'(bus.o_err), exp_err);
        chk("viol_nofree", int'(bus.o_free), 0);
        tick();
        tick();
        chk("viol_err_sticky", int'(bus.o_err), exp_err);
        drain(7);
        chk("viol_err_kept", int'(bus.o_err), exp_err);
        do_reset();
        chk("viol_err_cleared", int'(bus.o_err), 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Backstop so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
